// File: rtl/core_pkg.sv
// Definitions shared by the pipeline controller and the pipeline registers.
package core_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_handshake_fsm.sv
// Data-memory req/gnt/rvalid sequencer for the memory op sitting in WB.
module lsu_handshake_fsm
    import core_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wb_mem_valid_i,
    input  logic wb_is_store_i,
    input  logic data_gnt_i,
    input  logic data_rvalid_i,
    output logic data_req_o,
    output logic mem_busy_o
);

    lsu_state_e state_q;
    lsu_state_e state_d;

    // Next state, request and busy decode (Mealy on gnt/rvalid)
    always_comb begin
        state_d    = state_q;
        data_req_o = 1'b0;
        mem_busy_o = 1'b0;
        case (state_q)
            IDLE: begin
                data_req_o = wb_mem_valid_i;
                if (wb_mem_valid_i) begin
                    if (data_gnt_i) begin
                        // A granted store retires immediately; a load still needs its data
                        mem_busy_o = !wb_is_store_i;
                        state_d    = wb_is_store_i ? IDLE : WAIT_RVALID;
                    end else begin
                        mem_busy_o = 1'b1;
                        state_d    = WAIT_GNT;
                    end
                end else begin
                    mem_busy_o = 1'b0;
                    state_d    = IDLE;
                end
            end
            WAIT_GNT: begin
                data_req_o = 1'b1;
                if (data_gnt_i) begin
                    mem_busy_o = !wb_is_store_i;
                    state_d    = wb_is_store_i ? IDLE : WAIT_RVALID;
                end else begin
                    mem_busy_o = 1'b1;
                    state_d    = WAIT_GNT;
                end
            end
            WAIT_RVALID: begin
                data_req_o = 1'b0;
                if (data_rvalid_i) begin
                    mem_busy_o = 1'b0;
                    state_d    = IDLE;
                end else begin
                    mem_busy_o = 1'b1;
                    state_d    = WAIT_RVALID;
                end
            end
            default: begin
                data_req_o = 1'b0;
                mem_busy_o = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stall and clear controls for the four-stage core,
// load-use bubbles, branch flush and a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  ex_load_i,
    input  logic [ADDR_WIDTH-1:0] ex_reg_waddr_i,
    input  logic                  wb_mem_valid_i,
    input  logic                  wb_is_store_i,
    input  logic                  wb_branch_taken_i,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic                  data_req_o,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_clear_o,
    output logic                  id_ex_stall_o,
    output logic                  id_ex_clear_o,
    output logic                  ex_wb_stall_o,
    output logic                  ex_wb_clear_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    logic                 fsm_req_s;
    logic                 mem_busy_s;
    logic                 load_use_s;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;

    lsu_handshake_fsm u_lsu_fsm (
        .clk            (clk),
        .rst            (rst),
        .wb_mem_valid_i (wb_mem_valid_i),
        .wb_is_store_i  (wb_is_store_i),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_req_o     (fsm_req_s),
        .mem_busy_o     (mem_busy_s)
    );

    // x0 is never a real dependency, so a load targeting it cannot cause a bubble
    assign load_use_s = ex_load_i && (ex_reg_waddr_i != {ADDR_WIDTH{1'b0}}) &&
                        ((id_rs1_used_i && (id_rs1_addr_i == ex_reg_waddr_i)) ||
                         (id_rs2_used_i && (id_rs2_addr_i == ex_reg_waddr_i)));

    // Priority mux: reset, memory busy, branch flush, load-use bubble
    always_comb begin
        data_req_o    = 1'b0;
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        if_id_clear_o = 1'b0;
        id_ex_stall_o = 1'b0;
        id_ex_clear_o = 1'b0;
        ex_wb_stall_o = 1'b0;
        ex_wb_clear_o = 1'b0;
        if (rst) begin
            if_id_clear_o = 1'b1;
            id_ex_clear_o = 1'b1;
            ex_wb_clear_o = 1'b1;
        end else if (mem_busy_s) begin
            data_req_o    = fsm_req_s;
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            ex_wb_stall_o = 1'b1;
        end else if (wb_branch_taken_i) begin
            data_req_o    = fsm_req_s;
            if_id_clear_o = 1'b1;
            id_ex_clear_o = 1'b1;
            ex_wb_clear_o = 1'b1;
        end else if (load_use_s) begin
            data_req_o    = fsm_req_s;
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_clear_o = 1'b1;
        end else begin
            data_req_o    = fsm_req_s;
        end
    end

    // Saturating count of PC-hold cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall_o && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
